// File: rtl/qarma64_pkg.sv
// Shared QARMA-64 definitions: block/cell types, sequencer states, cell-level
// helpers used by the round logic, and the constants consumed by the
// tweakey-schedule block.
package qarma64_pkg;

  localparam int BLK_W  = 64;
  localparam int CELL_W = 4;

  typedef logic [BLK_W-1:0] qblk_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fsm_t;

  // Round constants and reflection constant (tweakey-schedule use).
  localparam qblk_t C0    = 64'h0000000000000000;
  localparam qblk_t C1    = 64'h13198A2E03707344;
  localparam qblk_t C2    = 64'hA4093822299F31D0;
  localparam qblk_t C3    = 64'h082EFA98EC4E6C89;
  localparam qblk_t C4    = 64'h452821E638D01377;
  localparam qblk_t C5    = 64'hBE5466CF34E90C6C;
  localparam qblk_t C6    = 64'h3F84D5B5B5470917;
  localparam qblk_t C7    = 64'h9216D5D98979FB1B;
  localparam qblk_t ALPHA = 64'hC0AC29B7C97C50DD;

  // sigma1 S-box; it is an involution, so it also serves as its own inverse.
  function automatic logic [CELL_W-1:0] sbox(input logic [CELL_W-1:0] x);
    logic [CELL_W-1:0] y;
    case (x)
      4'h0: y = 4'hA;  4'h1: y = 4'hD;  4'h2: y = 4'hE;  4'h3: y = 4'h6;
      4'h4: y = 4'hF;  4'h5: y = 4'h7;  4'h6: y = 4'h3;  4'h7: y = 4'h5;
      4'h8: y = 4'h9;  4'h9: y = 4'h8;  4'hA: y = 4'h0;  4'hB: y = 4'hC;
      4'hC: y = 4'hB;  4'hD: y = 4'h1;  4'hE: y = 4'h2;  default: y = 4'h4;
    endcase
    return y;
  endfunction

  // rho: rotate a cell left by one bit; rho2 rotates by two.
  function automatic logic [CELL_W-1:0] rho(input logic [CELL_W-1:0] x);
    return {x[2:0], x[3]};
  endfunction

  function automatic logic [CELL_W-1:0] rho2(input logic [CELL_W-1:0] x);
    return {x[1:0], x[3:2]};
  endfunction

endpackage

// File: rtl/qarma64_iround.sv
// Combinational QARMA-64 inverse round:
// SubCells -> MixColumns circ(0,rho,rho^2,rho) -> InvShuffleCells -> XOR tk.
// Cell i occupies bits [63-4i -: 4]; the 4x4 grid is row-major (cell = 4*row + col).
module qarma64_iround
  import qarma64_pkg::*;
(
  input  qblk_t indata,
  input  qblk_t tk,
  output qblk_t outdata
);

  typedef logic [0:15][CELL_W-1:0] cells_t;

  // Inverse of the shuffle tau = {0,11,6,13,10,1,12,7,5,14,3,8,15,4,9,2}.
  localparam int TAU_INV [16] = '{0, 5, 15, 10, 13, 8, 2, 7, 11, 14, 4, 1, 6, 3, 9, 12};

  cells_t in_c;
  cells_t sub_c;
  cells_t mix_c;
  cells_t shuf_c;

  assign in_c = indata;

  // Cell-level substitution, column mixing and inverse shuffle.
  always_comb begin
    sub_c  = '0;
    mix_c  = '0;
    shuf_c = '0;
    for (int i = 0; i < 16; i++) begin
      sub_c[i] = sbox(in_c[i]);
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mix_c[4*r+c] = rho(sub_c[4*((r+1)%4)+c])
                     ^ rho2(sub_c[4*((r+2)%4)+c])
                     ^ rho(sub_c[4*((r+3)%4)+c]);
      end
    end
    for (int i = 0; i < 16; i++) begin
      shuf_c[i] = mix_c[TAU_INV[i]];
    end
  end

  assign outdata = qblk_t'(shuf_c) ^ tk;

endmodule

// File: rtl/qarma64_iround_seq.sv
// Iterative QARMA-64 backward half: one inverse round per clock over ROUNDS
// rounds, tweakeys fetched by index (ROUNDS-1 down to 0) from an external table.
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// is held with stable data until accepted, and ready never depends on the
// same port's valid.
module qarma64_iround_seq
  import qarma64_pkg::*;
#(
  parameter int ROUNDS = 7,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic [IDX_W-1:0] rk_idx,
  input  logic [63:0]      rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             busy
);

  localparam logic [IDX_W-1:0] CNT_LOAD = IDX_W'(ROUNDS - 1);

  fsm_t             fsm_q, fsm_d;
  qblk_t            state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  qblk_t            round_out;
  logic             accept;

  qarma64_iround u_iround (
    .indata  (state_q),
    .tk      (rk_data),
    .outdata (round_out)
  );

  // DONE can hand off and accept in the same cycle, giving back-to-back blocks.
  assign in_ready  = (fsm_q == ST_IDLE) || ((fsm_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign rk_idx    = (fsm_q == ST_RUN) ? cnt_q : '0;
  assign busy      = (fsm_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = state_q;

  // Next-state logic: load on accept, one round per RUN cycle, hold in DONE.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = in_data;
          cnt_d   = CNT_LOAD;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        if (cnt_q == '0) begin
          fsm_d       = ST_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (accept) begin
          state_d     = in_data;
          cnt_d       = CNT_LOAD;
          fsm_d       = ST_RUN;
          out_valid_d = 1'b0;
        end else if (out_ready) begin
          fsm_d       = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        fsm_d       = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_qarma64_iround_seq.sv
// Directed bench for qarma64_iround_seq: a ROUNDS=7 instance and a ROUNDS=1
// instance, each fed from its own tweakey table.
module tb_qarma64_iround_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ROUNDS=7 instance signals
  logic        in_valid7 = 1'b0, out_ready7 = 1'b0;
  logic        in_ready7, out_valid7, busy7;
  logic [63:0] in_data7 = '0;
  logic [63:0] rk_data7, out_data7;
  logic [2:0]  rk_idx7;
  logic [63:0] rk_tab7 [8];
  assign rk_data7 = rk_tab7[rk_idx7];

  // ROUNDS=1 instance signals
  logic        in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic        in_ready1, out_valid1, busy1;
  logic [63:0] in_data1 = '0;
  logic [63:0] rk_data1, out_data1;
  logic [2:0]  rk_idx1;
  logic [63:0] rk_tab1 [8];
  assign rk_data1 = rk_tab1[rk_idx1];

  qarma64_iround_seq #(.ROUNDS(7), .IDX_W(3)) u_dut7 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid7), .in_ready(in_ready7), .in_data(in_data7),
    .rk_idx(rk_idx7), .rk_data(rk_data7),
    .out_valid(out_valid7), .out_ready(out_ready7), .out_data(out_data7),
    .busy(busy7)
  );

  qarma64_iround_seq #(.ROUNDS(1), .IDX_W(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .rk_idx(rk_idx1), .rk_data(rk_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .busy(busy1)
  );

  // ---------------- reference model ----------------
  localparam int SBOX [16] = '{10, 13, 14, 6, 15, 7, 3, 5, 9, 8, 0, 12, 11, 1, 2, 4};
  localparam int TAU  [16] = '{0, 11, 6, 13, 10, 1, 12, 7, 5, 14, 3, 8, 15, 4, 9, 2};
  localparam int ROT  [4]  = '{0, 1, 2, 1};

  function automatic int rotl4(input int v, input int n);
    return ((v << n) | (v >> (4 - n))) & 15;
  endfunction

  function automatic logic [63:0] model_iround(input logic [63:0] x, input logic [63:0] tk);
    int s [16];
    int m [16];
    int p [16];
    logic [63:0] r;
    for (int i = 0; i < 16; i++) s[i] = SBOX[int'(x[63-4*i -: 4])];
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        m[4*row+col] = 0;
        for (int k = 1; k < 4; k++)
          m[4*row+col] = m[4*row+col] ^ rotl4(s[4*((row+k)%4)+col], ROT[k]);
      end
    end
    // tau^-1 by scattering: the cell at position k moves to position tau[k]
    for (int k = 0; k < 16; k++) p[TAU[k]] = m[k];
    for (int i = 0; i < 16; i++) r[63-4*i -: 4] = 4'(p[i]);
    return r ^ tk;
  endfunction

  function automatic logic [63:0] model_run(input logic [63:0] x, input logic [63:0] tab [8],
                                            input int rounds);
    logic [63:0] v;
    v = x;
    for (int i = rounds - 1; i >= 0; i--) v = model_iround(v, tab[i]);
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  int idx_q [$];
  logic [63:0] exp_q [$];

  // Present one block, then wait for out_valid; lat counts edges after the accept edge.
  task automatic run_block(input bit sel, input logic [63:0] din,
                           output logic [63:0] dout, output int lat);
    int guard;
    idx_q.delete();
    guard = 0;
    @(negedge clk);
    while (!(sel ? in_ready1 : in_ready7) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sel) begin in_valid1 = 1'b1; in_data1 = din; end
    else     begin in_valid7 = 1'b1; in_data7 = din; end
    @(negedge clk);
    in_valid1 = 1'b0;
    in_valid7 = 1'b0;
    lat = 0;
    while (!(sel ? out_valid1 : out_valid7) && lat < 50) begin
      if (!sel && busy7) idx_q.push_back(int'(rk_idx7));
      @(negedge clk);
      lat++;
    end
    dout = sel ? out_data1 : out_data7;
  endtask

  // Consume the pending result with a one-cycle out_ready pulse.
  task automatic release_out(input bit sel);
    if (sel) out_ready1 = 1'b1; else out_ready7 = 1'b1;
    @(negedge clk);
    out_ready1 = 1'b0;
    out_ready7 = 1'b0;
  endtask

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  logic [63:0] tab_a [8];
  logic [63:0] blk [3];
  logic [63:0] dout, held;
  int lat, k, got, cyc, vcount;
  int acc [3];

  initial begin
    for (int i = 0; i < 8; i++) begin
      tab_a[i]   = 64'h1111111111111111 * 64'(i);
      rk_tab7[i] = tab_a[i];
      rk_tab1[i] = '0;
    end
    rk_tab1[0] = 64'hA5A5A5A5A5A5A5A5;

    // Reset values
    #2;
    check_val("rst_out_valid", 64'(out_valid7), 64'd0);
    check_val("rst_out_data",  out_data7, 64'd0);
    check_val("rst_rk_idx",    64'(rk_idx7), 64'd0);
    check_val("rst_busy",      64'(busy7), 64'd0);
    check_val("rst_in_ready",  64'(in_ready7), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. Basic block
    run_block(1'b0, 64'h0123456789ABCDEF, dout, lat);
    check_val("basic_latency", 64'(lat), 64'd7);
    check_val("basic_data", dout, model_run(64'h0123456789ABCDEF, tab_a, 7));
    release_out(1'b0);
    check_val("basic_idle", 64'(busy7), 64'd0);

    // 2. Zero tweakeys: S(0)=A, M keeps a uniform A state, next round S(A)=0,
    //    so seven rounds leave all cells at A.
    for (int i = 0; i < 8; i++) rk_tab7[i] = '0;
    run_block(1'b0, 64'h0, dout, lat);
    check_val("zero_data", dout, 64'hAAAAAAAAAAAAAAAA);
    check_val("zero_idx_count", 64'(idx_q.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      check_val($sformatf("zero_idx%0d", i),
                (i < idx_q.size()) ? 64'(idx_q[i]) : 64'hx, 64'(6 - i));

    // 3. Backpressure with a competing block offered
    held = out_data7;
    in_valid7 = 1'b1;
    in_data7  = 64'h5555555555555555;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_data",      out_data7, held);
      check_val("bp_in_ready",  64'(in_ready7), 64'd0);
      check_val("bp_out_valid", 64'(out_valid7), 64'd1);
    end
    in_valid7 = 1'b0;
    release_out(1'b0);
    check_val("bp_no_accept", 64'(busy7), 64'd0);

    // 4. Back-to-back stream
    for (int i = 0; i < 8; i++) rk_tab7[i] = tab_a[i];
    blk[0] = 64'hDEADBEEFCAFEF00D;
    blk[1] = 64'h0F1E2D3C4B5A6978;
    blk[2] = 64'h8000000000000001;
    exp_q.delete();
    k = 0; got = 0; cyc = 0;
    out_ready7 = 1'b1;
    while ((k < 3 || got < 3) && cyc < 100) begin
      @(negedge clk);
      #1;
      if (out_valid7) begin
        check_val("b2b_data", out_data7, (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx);
        got++;
      end
      if (k < 3) begin
        in_valid7 = 1'b1;
        in_data7  = blk[k];
        if (in_ready7) begin
          acc[k] = cyc;
          exp_q.push_back(model_run(blk[k], tab_a, 7));
          k++;
        end
      end else begin
        in_valid7 = 1'b0;
      end
      cyc++;
    end
    in_valid7 = 1'b0;
    @(negedge clk);
    out_ready7 = 1'b0;
    check_val("b2b_results", 64'(got), 64'd3);
    check_val("b2b_accepts", 64'(k), 64'd3);
    if (k == 3) begin
      check_val("b2b_gap01", 64'(acc[1] - acc[0]), 64'd8);
      check_val("b2b_gap12", 64'(acc[2] - acc[1]), 64'd8);
    end
    check_val("b2b_idle", 64'(busy7), 64'd0);

    // 5. Reset during RUN cycle 3
    @(negedge clk);
    in_valid7 = 1'b1;
    in_data7  = 64'h13579BDF02468ACE;
    @(negedge clk);
    in_valid7 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("mid_running", 64'(rk_idx7), 64'd4);
    rst_n = 1'b0;
    #1;
    check_val("mid_out_valid", 64'(out_valid7), 64'd0);
    check_val("mid_out_data",  out_data7, 64'd0);
    check_val("mid_rk_idx",    64'(rk_idx7), 64'd0);
    check_val("mid_busy",      64'(busy7), 64'd0);
    check_val("mid_in_ready",  64'(in_ready7), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid7 || busy7) vcount++;
    end
    check_val("mid_no_output", 64'(vcount), 64'd0);
    run_block(1'b0, 64'hFEDCBA9876543210, dout, lat);
    check_val("post_rst_latency", 64'(lat), 64'd7);
    check_val("post_rst_data", dout, model_run(64'hFEDCBA9876543210, tab_a, 7));
    release_out(1'b0);

    // 6. ROUNDS=1: S(F)=4, M maps uniform 4 to uniform 1, XOR A5.. gives B4..
    run_block(1'b1, 64'hFFFFFFFFFFFFFFFF, dout, lat);
    check_val("r1_latency", 64'(lat), 64'd1);
    check_val("r1_data_hand", dout, 64'hB4B4B4B4B4B4B4B4);
    check_val("r1_data_model", dout, model_iround(64'hFFFFFFFFFFFFFFFF, 64'hA5A5A5A5A5A5A5A5));
    release_out(1'b1);
    check_val("r1_idle", 64'(busy1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
